// File: rtl/periph_bus_fabric.sv
// periph_bus_fabric: single-master, two-slave peripheral bus bridge.
// Decodes m_addr[19:16] (0 -> slave 0, 1 -> slave 1, else decode error).
// The IDLE/ACCESS/RESP FSM keeps one transaction in flight. It latches the request,
// holds it until the selected slave answers, and returns the response for one cycle.
// Optional feature: define PERIPH_BUS_TIMEOUT_EN to abort an ACCESS that lasts
// TIMEOUT_CYCLES cycles without a ready. The abort returns ERR_RDATA and pulses bus_err.
module periph_bus_fabric #(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        m_valid,
  input  logic [30:0] m_addr,
  input  logic        m_write,
  input  logic [31:0] m_wdata,
  input  logic [3:0]  m_wstrb,
  output logic [31:0] m_rdata,
  output logic        m_ready,
  output logic        s0_valid,
  output logic [30:0] s0_addr,
  output logic        s0_write,
  output logic [31:0] s0_wdata,
  output logic [3:0]  s0_wstrb,
  input  logic [31:0] s0_rdata,
  input  logic        s0_ready,
  output logic        s1_valid,
  output logic [30:0] s1_addr,
  output logic        s1_write,
  output logic [31:0] s1_wdata,
  output logic [3:0]  s1_wstrb,
  input  logic [31:0] s1_rdata,
  input  logic        s1_ready,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_nxt;
  logic        sel_q;
  logic [30:0] lat_addr;
  logic        lat_write;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_wstrb;
  logic [31:0] rdata_q;
  logic        bus_err_q;

  logic        dec_hit;
  logic        dec_sel;
  logic        sel_ready;
  logic        take;
  logic        capture;
  logic        err_set;
  logic        timeout;

  // Parameter range guard, evaluated at elaboration.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_param_chk
    $error("periph_bus_fabric: TIMEOUT_CYCLES out of range 2..65535");
  end

  // Only nibble values 0 and 1 in bits 19:16 map to a slave.
  assign dec_hit   = (m_addr[19:17] == 3'b000);
  assign dec_sel   = m_addr[16];
  // Ready from the slave that is not selected is never looked at.
  assign sel_ready = sel_q ? s1_ready : s0_ready;

`ifdef PERIPH_BUS_TIMEOUT_EN
  logic [15:0] to_cnt;

  // Count the cycles spent in ACCESS. The count restarts when a new request is latched.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (take) begin
      to_cnt <= '0;
    end else if (state == ACCESS) begin
      to_cnt <= to_cnt + 16'd1;
    end
  end

  assign timeout = (state == ACCESS) && (to_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // Next-state decode. Completion is tested before timeout, so ready wins a tie.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    capture   = 1'b0;
    err_set   = 1'b0;
    unique case (state)
      IDLE: begin
        if (m_valid) begin
          if (dec_hit) begin
            state_nxt = ACCESS;
            take      = 1'b1;
          end else begin
            state_nxt = RESP;
            err_set   = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (sel_ready) begin
          state_nxt = RESP;
          capture   = 1'b1;
        end else if (timeout) begin
          state_nxt = RESP;
          err_set   = 1'b1;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register. Reset returns to IDLE from any state and drops any transaction in flight.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request latch, response capture and error pulse. Cleared so every output reads 0 in reset.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q     <= 1'b0;
      lat_addr  <= '0;
      lat_write <= 1'b0;
      lat_wdata <= '0;
      lat_wstrb <= '0;
      rdata_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= err_set;
      if (take) begin
        sel_q     <= dec_sel;
        lat_addr  <= m_addr;
        lat_write <= m_write;
        lat_wdata <= m_wdata;
        lat_wstrb <= m_wstrb;
      end
      if (capture) begin
        rdata_q <= sel_q ? s1_rdata : s0_rdata;
      end else if (err_set) begin
        rdata_q <= ERR_RDATA;
      end
    end
  end

  // Both slaves see the same latched request. Only the valid strobe is steered.
  assign s0_valid = (state == ACCESS) && !sel_q;
  assign s1_valid = (state == ACCESS) &&  sel_q;
  assign s0_addr  = lat_addr;
  assign s1_addr  = lat_addr;
  assign s0_write = lat_write;
  assign s1_write = lat_write;
  assign s0_wdata = lat_wdata;
  assign s1_wdata = lat_wdata;
  assign s0_wstrb = lat_wstrb;
  assign s1_wstrb = lat_wstrb;

  assign m_ready  = (state == RESP);
  assign m_rdata  = (state == RESP) ? rdata_q : 32'd0;
  assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_periph_bus_fabric.sv
// Directed testbench for periph_bus_fabric. Expected values are worked out by hand.
// When PERIPH_BUS_TIMEOUT_EN is defined, the timeout scenarios use TIMEOUT_CYCLES=8.
module tb_periph_bus_fabric;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        m_valid;
  logic [30:0] m_addr;
  logic        m_write;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata;
  logic        m_ready;
  logic        s0_valid, s0_write, s0_ready;
  logic [30:0] s0_addr;
  logic [31:0] s0_wdata, s0_rdata;
  logic [3:0]  s0_wstrb;
  logic        s1_valid, s1_write, s1_ready;
  logic [30:0] s1_addr;
  logic [31:0] s1_wdata, s1_rdata;
  logic [3:0]  s1_wstrb;
  logic        bus_err;

  int n_tests = 0;
  int n_fail  = 0;

  periph_bus_fabric #(.TIMEOUT_CYCLES(8), .ERR_RDATA(32'hDEAD_BEEF)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .m_valid(m_valid), .m_addr(m_addr), .m_write(m_write), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_ready(m_ready),
    .s0_valid(s0_valid), .s0_addr(s0_addr), .s0_write(s0_write), .s0_wdata(s0_wdata),
    .s0_wstrb(s0_wstrb), .s0_rdata(s0_rdata), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_addr(s1_addr), .s1_write(s1_write), .s1_wdata(s1_wdata),
    .s1_wstrb(s1_wstrb), .s1_rdata(s1_rdata), .s1_ready(s1_ready),
    .bus_err(bus_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; m_valid = 1'b0; m_addr = '0; m_write = 1'b0; m_wdata = '0; m_wstrb = '0;
    s0_ready = 1'b0; s0_rdata = '0; s1_ready = 1'b0; s1_rdata = '0;
    #3;
    n_tests++; if (m_ready !== 1'b0) begin n_fail++; $display("FAIL rst_m_ready got %b want 0", m_ready); end
    n_tests++; if (m_rdata !== 32'd0) begin n_fail++; $display("FAIL rst_m_rdata got %h want 0", m_rdata); end
    n_tests++; if ({s0_valid, s1_valid} !== 2'b00) begin n_fail++; $display("FAIL rst_valid got %b want 00", {s0_valid, s1_valid}); end
    n_tests++; if ({s0_addr, s0_wdata, s0_wstrb, s0_write} !== 68'd0) begin n_fail++; $display("FAIL rst_s0_req got %h want 0", {s0_addr, s0_wdata, s0_wstrb, s0_write}); end
    n_tests++; if ({s1_addr, s1_wdata, s1_wstrb, s1_write} !== 68'd0) begin n_fail++; $display("FAIL rst_s1_req got %h want 0", {s1_addr, s1_wdata, s1_wstrb, s1_write}); end
    n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL rst_bus_err got %b want 0", bus_err); end
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_read_s0();
    m_valid = 1'b1; m_addr = 31'h0000_0004; m_write = 1'b0;
    step();
    m_valid = 1'b0;
    n_tests++; if (s0_valid !== 1'b1) begin n_fail++; $display("FAIL rd0_s0_valid_c1 got %b want 1", s0_valid); end
    n_tests++; if (s1_valid !== 1'b0) begin n_fail++; $display("FAIL rd0_s1_valid_c1 got %b want 0", s1_valid); end
    n_tests++; if (s0_addr !== 31'h0000_0004) begin n_fail++; $display("FAIL rd0_s0_addr got %h want 0000004", s0_addr); end
    n_tests++; if (m_ready !== 1'b0) begin n_fail++; $display("FAIL rd0_m_ready_c1 got %b want 0", m_ready); end
    s0_ready = 1'b1; s0_rdata = 32'h0000_00A5;
    step();
    s0_ready = 1'b0; s0_rdata = '0;
    n_tests++; if (m_ready !== 1'b1) begin n_fail++; $display("FAIL rd0_m_ready_c2 got %b want 1", m_ready); end
    n_tests++; if (m_rdata !== 32'h0000_00A5) begin n_fail++; $display("FAIL rd0_m_rdata got %h want 000000a5", m_rdata); end
    n_tests++; if ({s0_valid, s1_valid} !== 2'b00) begin n_fail++; $display("FAIL rd0_valid_c2 got %b want 00", {s0_valid, s1_valid}); end
    step();
    n_tests++; if (m_ready !== 1'b0) begin n_fail++; $display("FAIL rd0_m_ready_c3 got %b want 0", m_ready); end
    n_tests++; if (m_rdata !== 32'd0) begin n_fail++; $display("FAIL rd0_m_rdata_c3 got %h want 0", m_rdata); end
  endtask

  task automatic test_write_s1();
    m_valid = 1'b1; m_addr = 31'h0001_0000; m_write = 1'b1; m_wdata = 32'h1234_5678; m_wstrb = 4'b0011;
    step();
    // The master changes everything during ACCESS. The latched request must not follow it.
    m_valid = 1'b0; m_addr = 31'h0000_0000; m_write = 1'b0; m_wdata = 32'hFFFF_FFFF; m_wstrb = 4'b1100;
    for (int i = 0; i < 4; i++) begin
      n_tests++; if ({s1_valid, s1_write} !== 2'b11) begin n_fail++; $display("FAIL wr1_valid_write c%0d got %b want 11", i + 1, {s1_valid, s1_write}); end
      n_tests++; if ({s1_addr, s1_wdata, s1_wstrb} !== {31'h0001_0000, 32'h1234_5678, 4'b0011}) begin n_fail++; $display("FAIL wr1_req c%0d got %h %h %b want 0010000 12345678 0011", i + 1, s1_addr, s1_wdata, s1_wstrb); end
      n_tests++; if ({s0_valid, m_ready} !== 2'b00) begin n_fail++; $display("FAIL wr1_s0v_mready c%0d got %b want 00", i + 1, {s0_valid, m_ready}); end
      if (i == 3) begin s1_ready = 1'b1; s1_rdata = 32'h0BAD_F00D; end
      step();
    end
    s1_ready = 1'b0; s1_rdata = '0;
    n_tests++; if (m_ready !== 1'b1) begin n_fail++; $display("FAIL wr1_m_ready got %b want 1", m_ready); end
    n_tests++; if (m_rdata !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL wr1_m_rdata got %h want 0badf00d", m_rdata); end
    n_tests++; if (s1_valid !== 1'b0) begin n_fail++; $display("FAIL wr1_s1_valid_drop got %b want 0", s1_valid); end
    n_tests++; if ({s0_wdata, s0_wstrb} !== {32'h1234_5678, 4'b0011}) begin n_fail++; $display("FAIL wr1_s0_shared got %h %b want 12345678 0011", s0_wdata, s0_wstrb); end
    step();
    n_tests++; if (m_ready !== 1'b0) begin n_fail++; $display("FAIL wr1_m_ready_after got %b want 0", m_ready); end
  endtask

  task automatic test_decode_err();
    m_valid = 1'b1; m_addr = 31'h0005_0000; m_write = 1'b0;
    #1;
    n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL derr_bus_err_c0 got %b want 0", bus_err); end
    step();
    m_valid = 1'b0;
    n_tests++; if (m_ready !== 1'b1) begin n_fail++; $display("FAIL derr_m_ready got %b want 1", m_ready); end
    n_tests++; if (m_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL derr_m_rdata got %h want deadbeef", m_rdata); end
    n_tests++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL derr_bus_err got %b want 1", bus_err); end
    n_tests++; if ({s0_valid, s1_valid} !== 2'b00) begin n_fail++; $display("FAIL derr_valid got %b want 00", {s0_valid, s1_valid}); end
    step();
    n_tests++; if ({bus_err, m_ready} !== 2'b00) begin n_fail++; $display("FAIL derr_after got %b want 00", {bus_err, m_ready}); end
    n_tests++; if ({s0_valid, s1_valid} !== 2'b00) begin n_fail++; $display("FAIL derr_valid_after got %b want 00", {s0_valid, s1_valid}); end
  endtask

  task automatic test_addr_upper_ignored();
    m_valid = 1'b1; m_addr = 31'h7FF0_0004; m_write = 1'b0;
    step();
    m_valid = 1'b0;
    n_tests++; if ({s0_valid, s1_valid} !== 2'b10) begin n_fail++; $display("FAIL upr_valid got %b want 10", {s0_valid, s1_valid}); end
    n_tests++; if (s0_addr !== 31'h7FF0_0004) begin n_fail++; $display("FAIL upr_s0_addr got %h want 7ff00004", s0_addr); end
    s0_ready = 1'b1; s0_rdata = 32'h0000_0011;
    step();
    s0_ready = 1'b0; s0_rdata = '0;
    n_tests++; if ({m_ready, bus_err} !== 2'b10) begin n_fail++; $display("FAIL upr_ready_err got %b want 10", {m_ready, bus_err}); end
    n_tests++; if (m_rdata !== 32'h0000_0011) begin n_fail++; $display("FAIL upr_m_rdata got %h want 00000011", m_rdata); end
    step();
  endtask

  task automatic test_ignore_other_ready();
    m_valid = 1'b1; m_addr = 31'h0000_0020; m_write = 1'b0;
    step();
    m_valid = 1'b0;
    s1_ready = 1'b1; s1_rdata = 32'hFFFF_0000;
    for (int i = 0; i < 2; i++) begin
      n_tests++; if ({s0_valid, s1_valid, m_ready} !== 3'b100) begin n_fail++; $display("FAIL oth_state c%0d got %b want 100", i + 1, {s0_valid, s1_valid, m_ready}); end
      step();
    end
    s1_ready = 1'b0; s1_rdata = '0;
    n_tests++; if ({s0_valid, m_ready} !== 2'b10) begin n_fail++; $display("FAIL oth_still_waiting got %b want 10", {s0_valid, m_ready}); end
    s0_ready = 1'b1; s0_rdata = 32'h0000_0040;
    step();
    s0_ready = 1'b0; s0_rdata = '0;
    n_tests++; if (m_ready !== 1'b1) begin n_fail++; $display("FAIL oth_m_ready got %b want 1", m_ready); end
    n_tests++; if (m_rdata !== 32'h0000_0040) begin n_fail++; $display("FAIL oth_m_rdata got %h want 00000040", m_rdata); end
    step();
  endtask

  task automatic test_timeout();
`ifdef PERIPH_BUS_TIMEOUT_EN
    m_valid = 1'b1; m_addr = 31'h0000_0010; m_write = 1'b0;
    step();
    m_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_tests++; if ({s0_valid, m_ready} !== 2'b10) begin n_fail++; $display("FAIL to_wait c%0d got %b want 10", i + 1, {s0_valid, m_ready}); end
      step();
    end
    n_tests++; if ({m_ready, bus_err, s0_valid} !== 3'b110) begin n_fail++; $display("FAIL to_abort got %b want 110", {m_ready, bus_err, s0_valid}); end
    n_tests++; if (m_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL to_m_rdata got %h want deadbeef", m_rdata); end
    step();
    n_tests++; if ({m_ready, bus_err} !== 2'b00) begin n_fail++; $display("FAIL to_after got %b want 00", {m_ready, bus_err}); end
    // Ready arrives in the same cycle the count expires. Normal completion takes priority.
    m_valid = 1'b1; m_addr = 31'h0000_0014;
    step();
    m_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin s0_ready = 1'b1; s0_rdata = 32'h0000_0077; end
      step();
    end
    s0_ready = 1'b0; s0_rdata = '0;
    n_tests++; if ({m_ready, bus_err} !== 2'b10) begin n_fail++; $display("FAIL to_tie_flags got %b want 10", {m_ready, bus_err}); end
    n_tests++; if (m_rdata !== 32'h0000_0077) begin n_fail++; $display("FAIL to_tie_rdata got %h want 00000077", m_rdata); end
    step();
`else
    int ready_seen = 0;
    m_valid = 1'b1; m_addr = 31'h0000_0010; m_write = 1'b0;
    step();
    m_valid = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (m_ready === 1'b1 || bus_err === 1'b1) ready_seen++;
      step();
    end
    n_tests++; if (ready_seen !== 0) begin n_fail++; $display("FAIL nto_ready_count got %0d want 0", ready_seen); end
    n_tests++; if (s0_valid !== 1'b1) begin n_fail++; $display("FAIL nto_s0_valid got %b want 1", s0_valid); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
`endif
  endtask

  task automatic test_reset_mid();
    m_valid = 1'b1; m_addr = 31'h0000_0008; m_write = 1'b0;
    step();
    m_valid = 1'b0;
    n_tests++; if (s0_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_s0_valid_pre got %b want 1", s0_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if ({s0_valid, m_ready} !== 2'b00) begin n_fail++; $display("FAIL rmid_async got %b want 00", {s0_valid, m_ready}); end
    n_tests++; if (s0_addr !== 31'd0) begin n_fail++; $display("FAIL rmid_s0_addr got %h want 0", s0_addr); end
    step(); step();
    rst_n = 1'b1;
    step();
    n_tests++; if ({s0_valid, s1_valid, m_ready} !== 3'b000) begin n_fail++; $display("FAIL rmid_no_resume got %b want 000", {s0_valid, s1_valid, m_ready}); end
    m_valid = 1'b1; m_addr = 31'h0000_000C;
    step();
    m_valid = 1'b0;
    n_tests++; if (s0_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_next_valid got %b want 1", s0_valid); end
    s0_ready = 1'b1; s0_rdata = 32'h0000_0055;
    step();
    s0_ready = 1'b0; s0_rdata = '0;
    n_tests++; if ({m_ready, m_rdata} !== {1'b1, 32'h0000_0055}) begin n_fail++; $display("FAIL rmid_next_resp got %b %h want 1 00000055", m_ready, m_rdata); end
    step();
  endtask

  initial begin
    test_reset();
    test_read_s0();
    test_write_s1();
    test_decode_err();
    test_addr_upper_ignored();
    test_ignore_other_ready();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/periph_bus_fabric.md
PERIPH_BUS_FABRIC -- requirements
Module: periph_bus_fabric

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: ACCESS-state cycles before timeout abort (valid range 2..65535).
REQ-002 Parameter ERR_RDATA, default 32'hDEAD_BEEF: read data returned on decode error or timeout.
REQ-003 sys_clk  in  1  sole clock; all state on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 m_valid/m_addr/m_write/m_wdata/m_wstrb  in  1/31/1/32/4  request from the CPU subsystem peripheral port.
REQ-006 m_rdata/m_ready  out  32/1  response to the CPU subsystem.
REQ-007 s0_valid/s0_addr/s0_write/s0_wdata/s0_wstrb  out  1/31/1/32/4  request to slave 0, the GPIO subsystem.
REQ-008 s0_rdata/s0_ready  in  32/1  response from slave 0.
REQ-009 s1_*  same widths and directions as s0_*; slave 1 is the next peripheral.
REQ-010 bus_err  out  1  one-cycle pulse on decode error or timeout.

Function
REQ-011 Decode on m_addr[19:16]: 4'h0 -> slave 0; 4'h1 -> slave 1; any other value -> error; m_addr[30:20] ignored.
REQ-012 FSM states: IDLE, ACCESS, RESP.
REQ-013 IDLE with m_valid=1 and a mapped address: latch addr/write/wdata/wstrb and slave select, then go to ACCESS.
REQ-014 IDLE with m_valid=1 and an unmapped address: go to RESP with data ERR_RDATA and pulse bus_err; no slave valid is asserted.
REQ-015 ACCESS: drive the selected sN_valid=1 from the latched request; all non-selected sN_valid=0.
REQ-016 ACCESS: hold the latched request stable until the selected sN_ready=1.
REQ-017 ACCESS with sN_ready=1: capture sN_rdata, drop sN_valid next cycle, go to RESP.
REQ-018 ACCESS: ignore ready from the non-selected slave.
REQ-019 RESP: m_ready=1 for exactly one cycle with m_rdata = captured data, then go to IDLE.
REQ-020 m_rdata is 0 whenever m_ready=0.
REQ-021 Latency for a zero-wait slave is m_valid rise at cycle 0, sN_valid at cycle 1, sN_ready at cycle 1, m_ready at cycle 2.
REQ-022 Writes return captured slave rdata, which is don't-care to the master.
REQ-023 Write data is forwarded unmodified and m_wstrb is passed through.
REQ-024 m_valid is sampled only in IDLE; changes in m_valid during ACCESS or RESP are ignored.
REQ-025 At most one transaction is in flight; there is no pipelining.
REQ-026 sN_addr, sN_wdata and sN_wstrb are driven from the latch to both slaves; only sN_valid is gated by the slave select.

Reset
REQ-027 rst_n low, at any state including mid-transaction, shall force IDLE.
REQ-028 On reset, all outputs shall be 0: m_ready, m_rdata, sN_valid, sN_addr, sN_wdata, sN_wstrb, sN_write and bus_err.
REQ-029 On reset, the timeout counter shall be cleared to 0.
REQ-030 An aborted transaction shall not be resumed after reset release.

Configuration
REQ-031 Macro PERIPH_BUS_TIMEOUT_EN defined: a 16-bit counter clears on ACCESS entry and increments each ACCESS cycle.
REQ-032 With the macro defined, reaching TIMEOUT_CYCLES without ready: drop sN_valid, go to RESP with ERR_RDATA, pulse bus_err.
REQ-033 With the macro defined, if sN_ready and the timeout coincide in the same cycle, ready wins (normal completion).
REQ-034 Macro undefined: no counter is instantiated; ACCESS waits indefinitely, and bus_err arises only from decode errors.

Verification
REQ-035 Read 0x0_0004, s0 returns ready at cycle 1 with 32'h0000_00A5 -> m_ready at cycle 2, m_rdata=32'h0000_00A5, s1_valid never 1.
REQ-036 Write 0x1_0000, wdata 32'h1234_5678, wstrb 4'b0011, s1 ready after 3 wait cycles -> s1 sees stable request for 4 cycles, m_ready one cycle later.
REQ-037 Read 0x5_0000 -> no sN_valid, m_ready at cycle 1 with 32'hDEAD_BEEF, bus_err pulse at cycle 1.
REQ-038 PERIPH_BUS_TIMEOUT_EN with TIMEOUT_CYCLES=8, s0 never ready -> s0_valid high 8 cycles, then m_ready with 32'hDEAD_BEEF and bus_err; without the macro, the wait does not terminate within 1000 cycles.
REQ-039 rst_n asserted during ACCESS -> s0_valid=0 and m_ready=0 asynchronously; after release, the next request is served normally.
REQ-040 s1_ready pulses while s0 is selected -> ignored; completion only on s0_ready.
